dram_port_arbiter: RTL and testbench

- N-channel arbiter between DRAM client blocks (initializer, address generator, future PosMap/integrity walkers) and the single DDR3 command/data interface.
- Generalised successor of the two-way initializer/address-generator mux in the ORAM backend.
- Adds round-robin arbitration, an exclusive lock input, and per-command owner tracking. Write data and read data are routed to/from the client that issued each command, in command order.

---
 rtl/dram_port_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_dram_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_port_arbiter.sv
// N-port arbiter onto one DDR3 command/data interface, with owner tracking of read/write data.
// Latency: zero on the command path, write data and read data; the RR pointer and the owner FIFOs update on the accept edge.
// Backpressure: DRAMCommandReady goes only to the granted port, and DRAMWriteDataReady only to the port at the write-owner head.
//
// Ports:
//   Clock, Reset (async, active-low), Lock (forces the grant to port 0).
//   InCommand*/InWrite* are per-port packed buses; port i occupies slice i.
//   OutReadData is broadcast to all ports. OutReadDataValid is one-hot to the owning port.
//   DRAM* signals connect to the DDR3 controller. ReadOrphan is a sticky flag for read data that arrives with no read outstanding.
// Build option: define DRAMARB_FIXED_PRIORITY_EN to grant the lowest-index eligible port (no RR pointer).

module dram_port_arbiter_fifo #(
    parameter int Width = 2,
    parameter int Depth = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Push,
    input  logic [Width-1:0] PushData,
    input  logic             Pop,
    output logic [Width-1:0] PopData,
    output logic             Full,
    output logic             Empty
);
    localparam int AW = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [AW-1:0]    wrPtr, rdPtr;
    logic [AW:0]      count;
    logic             doPush, doPop;

    assign Full    = (count == (AW+1)'(Depth));
    assign Empty   = (count == '0);
    assign doPush  = Push && !Full;
    assign doPop   = Pop && !Empty;
    assign PopData = mem[rdPtr];

    always_ff @(posedge Clock) begin
        if (doPush) mem[wrPtr] <= PushData;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop)  rdPtr <= rdPtr + AW'(1);
            count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
        end
    end
endmodule

module dram_port_arbiter #(
    parameter int NumPorts    = 4,
    parameter int DDRAWidth   = 27,
    parameter int DDRCWidth   = 3,
    parameter int DDRDWidth   = 512,
    parameter int DDRMWidth   = 64,
    parameter int BeatsPerCmd = 1,
    parameter int OwnerDepth  = 16
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic                           Lock,
    input  logic [NumPorts*DDRAWidth-1:0]  InCommandAddress,
    input  logic [NumPorts*DDRCWidth-1:0]  InCommand,
    input  logic [NumPorts-1:0]            InCommandValid,
    output logic [NumPorts-1:0]            InCommandReady,
    input  logic [NumPorts*DDRDWidth-1:0]  InWriteData,
    input  logic [NumPorts*DDRMWidth-1:0]  InWriteMask,
    input  logic [NumPorts-1:0]            InWriteDataValid,
    output logic [NumPorts-1:0]            InWriteDataReady,
    output logic [DDRDWidth-1:0]           OutReadData,
    output logic [NumPorts-1:0]            OutReadDataValid,
    output logic [DDRAWidth-1:0]           DRAMCommandAddress,
    output logic [DDRCWidth-1:0]           DRAMCommand,
    output logic                           DRAMCommandValid,
    input  logic                           DRAMCommandReady,
    input  logic [DDRDWidth-1:0]           DRAMReadData,
    input  logic                           DRAMReadDataValid,
    output logic [DDRDWidth-1:0]           DRAMWriteData,
    output logic [DDRMWidth-1:0]           DRAMWriteMask,
    output logic                           DRAMWriteDataValid,
    input  logic                           DRAMWriteDataReady,
    output logic                           ReadOrphan
);
    localparam int PW = $clog2(NumPorts);
    localparam logic [DDRCWidth-1:0] CmdWrite = '0;
    localparam logic [DDRCWidth-1:0] CmdRead  = DDRCWidth'(1);
    localparam logic [1:0]           LastBeat = 2'(BeatsPerCmd-1);
    localparam logic [NumPorts-1:0]  OneHot0  = NumPorts'(1);

    logic [NumPorts-1:0] eligible;
    logic                grantFound;
    logic [PW-1:0]       grantIdx;
    logic                accept;
    logic                wrFull, wrEmpty, rdFull, rdEmpty;
    logic [PW-1:0]       wrHead, rdHead;
    logic [1:0]          wrBeat, rdBeat;
    logic                wrXfer, rdXfer;
    logic                wrPop, rdPop;
    int                  startIdx;

`ifdef DRAMARB_FIXED_PRIORITY_EN
    assign startIdx = 0;
`else
    logic [PW-1:0] rrPtr;
    assign startIdx = int'(rrPtr);
`endif

    // Eligibility and grant search from startIdx with wrap-around.
    always_comb begin
        int idx;
        eligible   = '0;
        grantFound = 1'b0;
        grantIdx   = '0;
        idx        = 0;
        for (int i = 0; i < NumPorts; i++) begin
            logic [DDRCWidth-1:0] c;
            c = InCommand[i*DDRCWidth +: DDRCWidth];
            eligible[i] = InCommandValid[i]
                          && !((c == CmdWrite) && wrFull)
                          && !((c == CmdRead) && rdFull);
        end
        if (Lock) eligible = eligible & OneHot0;
        for (int k = 0; k < NumPorts; k++) begin
            idx = startIdx + k;
            if (idx >= NumPorts) idx = idx - NumPorts;
            if (!grantFound && eligible[PW'(idx)]) begin
                grantFound = 1'b1;
                grantIdx   = PW'(idx);
            end
        end
    end

    // Valid/ready outputs are gated by Reset so that they drop the moment reset asserts.
    assign DRAMCommandAddress = InCommandAddress[int'(grantIdx)*DDRAWidth +: DDRAWidth];
    assign DRAMCommand        = InCommand[int'(grantIdx)*DDRCWidth +: DDRCWidth];
    assign DRAMCommandValid   = grantFound && Reset;
    assign InCommandReady     = (DRAMCommandValid && DRAMCommandReady) ? (OneHot0 << grantIdx) : '0;
    assign accept             = DRAMCommandValid && DRAMCommandReady;

`ifndef DRAMARB_FIXED_PRIORITY_EN
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)      rrPtr <= '0;
        else if (accept) rrPtr <= (grantIdx == PW'(NumPorts-1)) ? '0 : grantIdx + PW'(1);
    end
`endif

    dram_port_arbiter_fifo #(.Width(PW), .Depth(OwnerDepth)) wrOwner (
        .Clock(Clock), .Reset(Reset),
        .Push(accept && (DRAMCommand == CmdWrite)), .PushData(grantIdx),
        .Pop(wrPop), .PopData(wrHead), .Full(wrFull), .Empty(wrEmpty)
    );

    dram_port_arbiter_fifo #(.Width(PW), .Depth(OwnerDepth)) rdOwner (
        .Clock(Clock), .Reset(Reset),
        .Push(accept && (DRAMCommand == CmdRead)), .PushData(grantIdx),
        .Pop(rdPop), .PopData(rdHead), .Full(rdFull), .Empty(rdEmpty)
    );

    // Write data: only the head owner is connected, so data can never precede its command.
    assign DRAMWriteData      = InWriteData[int'(wrHead)*DDRDWidth +: DDRDWidth];
    assign DRAMWriteMask      = InWriteMask[int'(wrHead)*DDRMWidth +: DDRMWidth];
    assign DRAMWriteDataValid = !wrEmpty && Reset && InWriteDataValid[wrHead];
    assign InWriteDataReady   = (!wrEmpty && Reset && DRAMWriteDataReady) ? (OneHot0 << wrHead) : '0;
    assign wrXfer             = DRAMWriteDataValid && DRAMWriteDataReady;
    assign wrPop              = wrXfer && (wrBeat == LastBeat);

    // Read data: steer to the head owner. Beats with no owner are dropped and flagged.
    assign OutReadData      = DRAMReadData;
    assign rdXfer           = DRAMReadDataValid && !rdEmpty && Reset;
    assign OutReadDataValid = rdXfer ? (OneHot0 << rdHead) : '0;
    assign rdPop            = rdXfer && (rdBeat == LastBeat);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wrBeat     <= '0;
            rdBeat     <= '0;
            ReadOrphan <= 1'b0;
        end else begin
            if (wrXfer) wrBeat <= (wrBeat == LastBeat) ? 2'd0 : wrBeat + 2'd1;
            if (rdXfer) rdBeat <= (rdBeat == LastBeat) ? 2'd0 : rdBeat + 2'd1;
            if (DRAMReadDataValid && rdEmpty) ReadOrphan <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dram_port_arbiter.sv
module tb_dram_port_arbiter;
    localparam int NP = 4, AW = 27, CW = 3, DW = 512, MW = 64;
    localparam logic [CW-1:0] WR = 3'b000, RD = 3'b001;

    logic                 Clock = 1'b0;
    logic                 Reset = 1'b0;
    logic                 Lock = 1'b0;
    logic [NP*AW-1:0]     InCommandAddress = '0;
    logic [NP*CW-1:0]     InCommand = '0;
    logic [NP-1:0]        InCommandValid = '0;
    logic [NP-1:0]        InCommandReady;
    logic [NP*DW-1:0]     InWriteData = '0;
    logic [NP*MW-1:0]     InWriteMask = '0;
    logic [NP-1:0]        InWriteDataValid = '0;
    logic [NP-1:0]        InWriteDataReady;
    logic [DW-1:0]        OutReadData;
    logic [NP-1:0]        OutReadDataValid;
    logic [AW-1:0]        DRAMCommandAddress;
    logic [CW-1:0]        DRAMCommand;
    logic                 DRAMCommandValid;
    logic                 DRAMCommandReady = 1'b0;
    logic [DW-1:0]        DRAMReadData = '0;
    logic                 DRAMReadDataValid = 1'b0;
    logic [DW-1:0]        DRAMWriteData;
    logic [MW-1:0]        DRAMWriteMask;
    logic                 DRAMWriteDataValid;
    logic                 DRAMWriteDataReady = 1'b0;
    logic                 ReadOrphan;

    dram_port_arbiter dut (
        .Clock(Clock), .Reset(Reset), .Lock(Lock),
        .InCommandAddress(InCommandAddress), .InCommand(InCommand),
        .InCommandValid(InCommandValid), .InCommandReady(InCommandReady),
        .InWriteData(InWriteData), .InWriteMask(InWriteMask),
        .InWriteDataValid(InWriteDataValid), .InWriteDataReady(InWriteDataReady),
        .OutReadData(OutReadData), .OutReadDataValid(OutReadDataValid),
        .DRAMCommandAddress(DRAMCommandAddress), .DRAMCommand(DRAMCommand),
        .DRAMCommandValid(DRAMCommandValid), .DRAMCommandReady(DRAMCommandReady),
        .DRAMReadData(DRAMReadData), .DRAMReadDataValid(DRAMReadDataValid),
        .DRAMWriteData(DRAMWriteData), .DRAMWriteMask(DRAMWriteMask),
        .DRAMWriteDataValid(DRAMWriteDataValid), .DRAMWriteDataReady(DRAMWriteDataReady),
        .ReadOrphan(ReadOrphan)
    );

    always #5 Clock = ~Clock;

    int nComp = 0;
    int nFail = 0;
    int rdQ[$];             // expected read owners, in command order
    int wrQ[$];             // expected write owners, in command order
    int rrModel = 0;
    logic [CW-1:0] cmdOf [NP];
    logic [AW-1:0] addrOf [NP];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        nComp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NP-1:0] oh(input int p);
        logic [NP-1:0] one;
        one = 1;
        return (p < 0) ? '0 : (one << p);
    endfunction

    function automatic int pickGrant(input logic [NP-1:0] elig, input int rr, input logic lk);
        if (lk) return elig[0] ? 0 : -1;
        for (int k = 0; k < NP; k++) begin
            if (elig[(rr + k) % NP]) return (rr + k) % NP;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] rndBeat();
        logic [DW-1:0] d;
        for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic setCmd(input int p, input logic [CW-1:0] c, input logic v);
        cmdOf[p] = c;
        addrOf[p] = AW'(32'h100 + p * 32'h11 + 32'($urandom_range(0, 255)) * 32'h1000);
        InCommand[p*CW +: CW] = c;
        InCommandAddress[p*AW +: AW] = addrOf[p];
        InCommandValid[p] = v;
    endtask

    task automatic setWr(input int p, input logic [DW-1:0] d, input logic [MW-1:0] m, input logic v);
        InWriteData[p*DW +: DW] = d;
        InWriteMask[p*MW +: MW] = m;
        InWriteDataValid[p] = v;
    endtask

    // One command cycle: the expected grant comes from the bench model. The owner is queued on accept.
    task automatic cmdCycle(input string tag, input logic [NP-1:0] elig);
        int g;
        #1;
        g = pickGrant(elig, rrModel, Lock);
        chk({tag, "_cmdvld"}, DW'(DRAMCommandValid), DW'(g >= 0));
        chk({tag, "_rdy"}, DW'(InCommandReady), DW'(oh(g)));
        if (g >= 0) begin
            chk({tag, "_addr"}, DW'(DRAMCommandAddress), DW'(addrOf[g]));
            chk({tag, "_cmd"}, DW'(DRAMCommand), DW'(cmdOf[g]));
            if (cmdOf[g] == RD) rdQ.push_back(g);
            if (cmdOf[g] == WR) wrQ.push_back(g);
            rrModel = (g + 1) % NP;
        end
        tick();
    endtask

    task automatic retRead(input string tag);
        logic [DW-1:0] d;
        int p;
        d = rndBeat();
        DRAMReadData = d;
        DRAMReadDataValid = 1'b1;
        #1;
        p = (rdQ.size() > 0) ? rdQ.pop_front() : -1;
        chk({tag, "_rvld"}, DW'(OutReadDataValid), DW'(oh(p)));
        chk({tag, "_rdat"}, OutReadData, d);
        tick();
        DRAMReadDataValid = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] dA, dB;
        logic [MW-1:0] mA;

        // Reset state, with all ports requesting.
        for (int p = 0; p < NP; p++) setCmd(p, RD, 1'b1);
        DRAMCommandReady = 1'b1;
        #2;
        chk("rst_cmdvld", DW'(DRAMCommandValid), '0);
        chk("rst_rdy", DW'(InCommandReady), '0);
        chk("rst_wvld", DW'(DRAMWriteDataValid), '0);
        chk("rst_wrdy", DW'(InWriteDataReady), '0);
        chk("rst_rvld", DW'(OutReadDataValid), '0);
        chk("rst_orphan", DW'(ReadOrphan), '0);
        tick();
        Reset = 1'b1;

        // Round-robin: four continuous readers.
        for (int i = 0; i < 5; i++) cmdCycle($sformatf("rr%0d", i), 4'b1111);
        InCommandValid = '0;
        for (int i = 0; i < 5; i++) retRead($sformatf("rrret%0d", i));

        // Write data ordering: B's data waits behind A's.
        dA = rndBeat(); dB = rndBeat(); mA = 64'hF0F0_1234_5678_9ABC;
        setCmd(1, WR, 1'b1);
        cmdCycle("wrA", 4'b0010);
        InCommandValid = '0;
        setCmd(2, WR, 1'b1);
        cmdCycle("wrB", 4'b0100);
        InCommandValid = '0;
        DRAMWriteDataReady = 1'b1;
        setWr(2, dB, '1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("wstall_vld", DW'(DRAMWriteDataValid), '0);
            chk("wstall_rdy", DW'(InWriteDataReady), DW'(oh(wrQ[0])));
            tick();
        end
        setWr(1, dA, mA, 1'b1);
        #1;
        chk("wA_vld", DW'(DRAMWriteDataValid), 1);
        chk("wA_rdy", DW'(InWriteDataReady), DW'(oh(wrQ.pop_front())));
        chk("wA_dat", DRAMWriteData, dA);
        chk("wA_msk", DW'(DRAMWriteMask), DW'(mA));
        tick();
        setWr(1, '0, '0, 1'b0);
        #1;
        chk("wB_vld", DW'(DRAMWriteDataValid), 1);
        chk("wB_rdy", DW'(InWriteDataReady), DW'(oh(wrQ.pop_front())));
        chk("wB_dat", DRAMWriteData, dB);
        tick();
        #1;
        chk("wempty_vld", DW'(DRAMWriteDataValid), '0);
        tick();
        setWr(2, '0, '0, 1'b0);

        // Owner FIFO full: 16 writes without data; the 17th stalls while a read proceeds.
        DRAMWriteDataReady = 1'b0;
        setCmd(0, WR, 1'b1);
        for (int i = 0; i < 16; i++) cmdCycle($sformatf("fill%0d", i), 4'b0001);
        cmdCycle("full_stall", 4'b0000);
        setCmd(1, RD, 1'b1);
        cmdCycle("full_rd", 4'b0010);
        InCommandValid = '0;
        DRAMWriteDataReady = 1'b1;
        for (int i = 0; i < 16; i++) begin
            dA = rndBeat();
            setWr(0, dA, '1, 1'b1);
            #1;
            chk($sformatf("drain%0d_rdy", i), DW'(InWriteDataReady), DW'(oh(wrQ.pop_front())));
            chk($sformatf("drain%0d_dat", i), DRAMWriteData, dA);
            tick();
        end
        #1;
        chk("drained_vld", DW'(DRAMWriteDataValid), '0);
        setWr(0, '0, '0, 1'b0);
        retRead("fullret");

        // Lock: only port 0 while held; port 3 is granted as soon as Lock drops.
        setCmd(0, RD, 1'b1);
        setCmd(3, RD, 1'b1);
        Lock = 1'b1;
        cmdCycle("lock0", 4'b1001);
        cmdCycle("lock1", 4'b1001);
        Lock = 1'b0;
        cmdCycle("unlock", 4'b1001);
        InCommandValid = '0;
        for (int i = 0; i < 3; i++) retRead($sformatf("lockret%0d", i));

        // Orphan read beat.
        DRAMReadData = rndBeat();
        DRAMReadDataValid = 1'b1;
        #1;
        chk("orph_rvld", DW'(OutReadDataValid), '0);
        chk("orph_pre", DW'(ReadOrphan), '0);
        tick();
        DRAMReadDataValid = 1'b0;
        #1;
        chk("orph_set", DW'(ReadOrphan), 1);
        tick(); tick(); tick();
        chk("orph_sticky", DW'(ReadOrphan), 1);

        // Reset with three writes outstanding.
        DRAMWriteDataReady = 1'b0;
        setCmd(2, WR, 1'b1);
        for (int i = 0; i < 3; i++) cmdCycle($sformatf("pre%0d", i), 4'b0100);
        setCmd(1, WR, 1'b1);
        setCmd(3, WR, 1'b1);
        setWr(2, rndBeat(), '1, 1'b1);
        DRAMWriteDataReady = 1'b1;
        #2;
        Reset = 1'b0;
        #1;
        chk("mrst_cmdvld", DW'(DRAMCommandValid), '0);
        chk("mrst_rdy", DW'(InCommandReady), '0);
        chk("mrst_wvld", DW'(DRAMWriteDataValid), '0);
        chk("mrst_wrdy", DW'(InWriteDataReady), '0);
        chk("mrst_orphan", DW'(ReadOrphan), '0);
        wrQ.delete();
        rrModel = 0;
        tick(); tick();
        Reset = 1'b1;
        InCommandValid = '0;
        #1;
        chk("post_wvld", DW'(DRAMWriteDataValid), '0);
        chk("post_wrdy", DW'(InWriteDataReady), '0);
        setWr(2, '0, '0, 1'b0);
        for (int p = 0; p < NP; p++) setCmd(p, RD, 1'b1);
        cmdCycle("post_grant", 4'b1111);
        InCommandValid = '0;
        retRead("postret");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
        $finish;
    end
endmodule
